// File: rtl/kitt_fader_if.sv
// rtl/kitt_fader_if.sv - CPU bus bundle for the kitt_fader register block
//
// Purpose: groups the simple zero-wait-state CPU bus signals.
// Signals:
//   address_in      bus address (only bit 2 decoded by the peripheral)
//   sel_in          peripheral select
//   read_value_out  read data of the addressed register
//   write_mask_in   byte write enables, all-zero means read
//   write_value_in  write data
//   ready_out       access acknowledge
// Modports: master drives the request, slave returns data/ready.
interface kitt_fader_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;

  modport master (
    output address_in, sel_in, write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );

  modport slave (
    input  address_in, sel_in, write_mask_in, write_value_in,
    output read_value_out, ready_out
  );
endinterface

// File: rtl/kitt_fader.sv
// rtl/kitt_fader.sv - PWM afterglow LED driver for the KITT scanner pattern
//
// Purpose: each lit pattern bit sets its LED to full brightness; once the bit
// drops the brightness decays linearly by CTRL.step every decay tick, and the
// brightness is rendered to the LED pin by a free-running PWM comparator.
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   pattern_in  scanner pattern, bit i requests LED i on
//   led_out     registered PWM drive, one bit per LED
//   bus         CPU register bus (slave): CTRL at bit2=0, PRESCALE at bit2=1
// Registers:
//   CTRL     = {23'b0, en[8], step[7:0]}
//   PRESCALE = clk cycles per decay tick minus 1
// Build option: define KITT_FADER_GAMMA_EN to square the brightness before
// the PWM compare (gamma ~2); otherwise duty is the linear level.
module kitt_fader #(
  parameter int          N_LEDS         = 5,
  parameter int          PWM_BITS       = 8,
  parameter logic [31:0] DECAY_PRESCALE = 32'd50000,
  parameter logic [7:0]  DECAY_STEP     = 8'd16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] pattern_in,
  output logic [N_LEDS-1:0] led_out,
  kitt_fader_if.slave       bus
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [7:0]          step_q, step_d;
  logic                en_q, en_d;
  logic [31:0]         prescale_q, prescale_d;
  logic [31:0]         tick_cnt_q, tick_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] level_q [N_LEDS];
  logic [PWM_BITS-1:0] level_d [N_LEDS];
  logic [PWM_BITS-1:0] duty    [N_LEDS];
  logic [N_LEDS-1:0]   led_q, led_d;

  logic tick;
  logic sel_ctrl;
  logic sel_pre;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.address_in[31:3], bus.address_in[1:0]};

  assign led_out = led_q;

  // Register file: combinational read, byte-masked write
  always_comb begin
    sel_ctrl = bus.sel_in & ~bus.address_in[2];
    sel_pre  = bus.sel_in &  bus.address_in[2];

    bus.ready_out      = bus.sel_in;
    bus.read_value_out = bus.address_in[2] ? prescale_q : {23'b0, en_q, step_q};

    step_d = step_q;
    en_d   = en_q;
    if (sel_ctrl && bus.write_mask_in[0]) step_d = bus.write_value_in[7:0];
    if (sel_ctrl && bus.write_mask_in[1]) en_d   = bus.write_value_in[8];

    prescale_d = prescale_q;
    for (int k = 0; k < 4; k++) begin
      if (sel_pre && bus.write_mask_in[k]) begin
        prescale_d[8*k +: 8] = bus.write_value_in[8*k +: 8];
      end
    end
  end

  // Decay tick: >= compare so a PRESCALE lowered below the running count
  // fires on the very next cycle instead of waiting for a 32-bit wrap.
  always_comb begin
    tick       = (tick_cnt_q >= prescale_q);
    tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
  end

  // Brightness levels and PWM compare
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      level_d[i] = level_q[i];
      if (!en_q) begin
        level_d[i] = pattern_in[i] ? MAX : '0;
      end else if (pattern_in[i]) begin
        level_d[i] = MAX;
      end else if (tick) begin
        // Saturating subtract; compared in a wider domain so a step larger
        // than MAX still clamps to zero.
        if ({8'b0, level_q[i]} > {{PWM_BITS{1'b0}}, step_q}) begin
          level_d[i] = level_q[i] - PWM_BITS'(step_q);
        end else begin
          level_d[i] = '0;
        end
      end

`ifdef KITT_FADER_GAMMA_EN
      duty[i] = PWM_BITS'(({{PWM_BITS{1'b0}}, level_q[i]} *
                           {{PWM_BITS{1'b0}}, level_q[i]}) >> PWM_BITS);
`else
      duty[i] = level_q[i];
`endif

      led_d[i] = (pwm_cnt_q < duty[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q     <= DECAY_STEP;
      en_q       <= 1'b1;
      prescale_q <= DECAY_PRESCALE;
      tick_cnt_q <= 32'd0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
      for (int i = 0; i < N_LEDS; i++) level_q[i] <= '0;
    end else begin
      step_q     <= step_d;
      en_q       <= en_d;
      prescale_q <= prescale_d;
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
      for (int i = 0; i < N_LEDS; i++) level_q[i] <= level_d[i];
    end
  end

endmodule

// File: tb/tb_kitt_fader.sv
// tb/tb_kitt_fader.sv - scoreboard testbench for kitt_fader
module tb_kitt_fader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] pattern_in = 5'b0;
  logic [4:0] led_out;

  kitt_fader_if bus();

  kitt_fader #(
    .N_LEDS(5),
    .PWM_BITS(8),
    .DECAY_PRESCALE(32'd50000),
    .DECAY_STEP(8'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pattern_in(pattern_in),
    .led_out(led_out),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef enum {K_READ, K_RDY, K_LED, K_LVL, K_DUTY} kind_e;
  typedef struct {
    int          at;
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

`ifdef KITT_FADER_GAMMA_EN
  localparam int DUTY_FULL = 254;
  localparam int DUTY_HALF = 64;
`else
  localparam int DUTY_FULL = 255;
  localparam int DUTY_HALF = 128;
`endif

  // Sorted insert so expectations may be queued in any order
  task automatic expect_at(input int at, input kind_e k, input int idx,
                           input logic [31:0] e, input string nm);
    exp_t item;
    int   pos;
    item = '{at, k, idx, e, nm};
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, item);
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] val);
    int t;
    t = cyc + 1;
    bus.sel_in         = 1'b1;
    bus.address_in     = addr;
    bus.write_mask_in  = mask;
    bus.write_value_in = val;
    tick_to(t);
    bus.sel_in        = 1'b0;
    bus.write_mask_in = 4'b0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, input logic [31:0] e,
                        input string nm);
    int t;
    t = cyc + 1;
    bus.sel_in        = 1'b1;
    bus.address_in    = addr;
    bus.write_mask_in = 4'b0;
    expect_at(cyc, K_READ, 0, e, nm);
    expect_at(cyc, K_RDY, 0, 32'd1, {nm, "_ready"});
    tick_to(t);
    bus.sel_in = 1'b0;
  endtask

  function automatic int pwm_after(input int k);
    return (k - rst_cyc) % 256;
  endfunction

  // Monitor: records led history and resolves every expectation due now
  logic [4:0]  hist [256];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          dsum;

  always @(negedge clk) begin
    hist[cyc % 256] = led_out;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_READ: mon_act = bus.read_value_out;
        K_RDY:  mon_act = {31'b0, bus.ready_out};
        K_LED:  mon_act = {27'b0, led_out};
        K_LVL:  mon_act = {24'b0, dut.level_q[mon_e.idx]};
        default: begin
          dsum = 0;
          for (int j = 0; j < 256; j++) begin
            if (hist[j][mon_e.idx] === 1'b1) dsum++;
          end
          mon_act = dsum;
        end
      endcase
      checks++;
      if (mon_e.at != cyc) begin
        errors++;
        $display("FAIL %s: check missed, due cycle %0d, seen at cycle %0d",
                 mon_e.name, mon_e.at, cyc);
      end else if (mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                 mon_e.name, mon_act, mon_e.exp, cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c, t, u, d, a, e;

    bus.sel_in         = 1'b0;
    bus.address_in     = 32'd0;
    bus.write_mask_in  = 4'b0;
    bus.write_value_in = 32'd0;

    // Reset values
    tick_to(3);
    reset   = 1'b0;
    rst_cyc = 3;
    expect_at(cyc, K_LED, 0, 32'd0, "rst_led");
    bus_rd(32'h0, 32'h0000_0110, "rst_ctrl");
    bus_rd(32'h4, 32'd50000, "rst_prescale");
    expect_at(cyc, K_RDY, 0, 32'd0, "ready_idle");
    tick_to(8);

    // Linear decay with PRESCALE=3, step=16
    c = cyc;
    expect_at(c + 3,  K_LVL, 0, 32'd255, "decay_load");
    expect_at(c + 5,  K_LVL, 0, 32'd255, "decay_hold");
    expect_at(c + 6,  K_LVL, 0, 32'd239, "decay_1");
    expect_at(c + 9,  K_LVL, 0, 32'd239, "decay_1_hold");
    expect_at(c + 10, K_LVL, 0, 32'd223, "decay_2");
    expect_at(c + 62, K_LVL, 0, 32'd15,  "decay_15");
    expect_at(c + 66, K_LVL, 0, 32'd0,   "decay_sat0");
    expect_at(c + 100, K_LVL, 0, 32'd0,  "decay_stay0");
    bus_wr(32'h4, 4'hF, 32'd3);
    tick_to(c + 2);
    pattern_in = 5'b00001;
    tick_to(c + 3);
    pattern_in = 5'b00000;
    tick_to(c + 101);

    // Load beats tick with PRESCALE=0
    t = cyc;
    expect_at(t + 1,   K_LVL, 2, 32'd255, "load_vs_tick_1");
    expect_at(t + 2,   K_LVL, 2, 32'd255, "load_vs_tick_2");
    expect_at(t + 50,  K_LVL, 2, 32'd255, "load_vs_tick_50");
    expect_at(t + 300, K_DUTY, 2, DUTY_FULL, "duty_full");
    pattern_in = 5'b00100;
    bus_wr(32'h4, 4'hF, 32'd0);
    tick_to(t + 301);

    // step=0 via byte-0 write, then en=0 passthrough
    u = cyc;
    bus_wr(32'h0, 4'b0001, 32'hFFFF_FF00);
    bus_rd(32'h0, 32'h0000_0100, "ctrl_step0");
    expect_at(u + 3,  K_LVL, 1, 32'd255, "step0_load");
    expect_at(u + 40, K_LVL, 1, 32'd255, "step0_hold1");
    expect_at(u + 40, K_LVL, 2, 32'd255, "step0_hold2");
    expect_at(u + 43, K_LVL, 2, 32'd0,   "en0_clear");
    pattern_in = 5'b00010;
    tick_to(u + 3);
    pattern_in = 5'b00000;
    tick_to(u + 41);
    bus_wr(32'h0, 4'b0010, 32'h0000_0000);
    bus_rd(32'h0, 32'h0000_0000, "ctrl_en0");
    tick_to(u + 45);
    d = cyc;
    while (pwm_after(d + 1) >= 254 || pwm_after(d + 2) >= 254) d++;
    expect_at(d + 1, K_LED, 0, 32'b00000, "pass_lat1");
    expect_at(d + 2, K_LED, 0, 32'b10101, "pass_lat2");
    expect_at(d + 3, K_LED, 0, 32'b10101, "pass_hold");
    expect_at(d + 4, K_LED, 0, 32'b00000, "pass_off");
    tick_to(d);
    pattern_in = 5'b10101;
    tick_to(d + 2);
    pattern_in = 5'b00000;
    tick_to(d + 5);
    bus_wr(32'h0, 4'b0011, 32'h0000_0110);
    bus_rd(32'h0, 32'h0000_0110, "ctrl_restore");

    // tick_cnt=100 then PRESCALE=10: tick next cycle, then every 11
    a = cyc;
    expect_at(a + 102, K_LVL, 3, 32'd255, "pre_hold");
    expect_at(a + 103, K_LVL, 3, 32'd239, "pre_tick_now");
    expect_at(a + 113, K_LVL, 3, 32'd239, "pre_gap");
    expect_at(a + 114, K_LVL, 3, 32'd223, "pre_tick_11");
    expect_at(a + 125, K_LVL, 3, 32'd207, "pre_tick_22");
    pattern_in = 5'b01000;
    bus_wr(32'h4, 4'hF, 32'd1000);
    tick_to(a + 101);
    pattern_in = 5'b00000;
    bus_wr(32'h4, 4'hF, 32'd10);

    // Half brightness: 255 - 127 = 128, then freeze with step=0
    expect_at(a + 135, K_LVL, 4, 32'd255, "half_load");
    expect_at(a + 136, K_LVL, 4, 32'd128, "half_level");
    expect_at(a + 200, K_LVL, 4, 32'd128, "half_hold");
    expect_at(a + 397, K_DUTY, 4, DUTY_HALF, "duty_half");
    tick_to(a + 126);
    pattern_in = 5'b10000;
    bus_wr(32'h0, 4'b0011, 32'h0000_017F);
    pattern_in = 5'b00000;
    tick_to(a + 137);
    bus_wr(32'h0, 4'b0001, 32'h0000_0000);
    tick_to(a + 398);

    // Reset mid-operation restores everything
    e = cyc;
    reset = 1'b1;
    tick_to(e + 1);
    reset   = 1'b0;
    rst_cyc = e + 1;
    expect_at(e + 1, K_LVL, 4, 32'd0, "mid_rst_level");
    expect_at(e + 1, K_LED, 0, 32'd0, "mid_rst_led");
    bus_rd(32'h0, 32'h0000_0110, "mid_rst_ctrl");
    bus_rd(32'h4, 32'd50000, "mid_rst_prescale");
    tick_to(e + 10);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
